// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
//   Constants and types shared by the matrix printer (and the command parser).
//   Contents: element/address widths, dimension limit, ASCII constants,
//   printer FSM states, the decimal-digit record and helpers that turn it into
//   characters.
// -----------------------------------------------------------------------------
package matrix_pkg;

  localparam int ELEM_W  = 8;
  localparam int ADDR_W  = 5;
  localparam int MAX_DIM = 5;
  localparam int HDR_LEN = 5;  // "M N\r\n"

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_RDWAIT,
    ST_EMIT,
    ST_SEP,
    ST_CR,
    ST_LF,
    ST_DONE
  } state_t;

  // Decimal breakdown of one element; ndigits counts significant digits (1..3).
  typedef struct packed {
    logic       neg;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [1:0] ndigits;
  } digits_t;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_ZERO + {4'd0, d};
  endfunction

  // Number of characters an element prints as (optional sign plus digits).
  function automatic logic [2:0] elem_len(input digits_t d);
    return {2'b00, d.neg} + {1'b0, d.ndigits};
  endfunction

  // Character at position pos of an element's text. Leading zeros are skipped
  // by offsetting into the fixed hund/tens/ones triple.
  function automatic logic [7:0] elem_char(input digits_t d, input logic [2:0] pos);
    logic [2:0] k;
    if (d.neg && pos == 3'd0) return ASCII_MINUS;
    k = pos - {2'b00, d.neg} + (3'd3 - {1'b0, d.ndigits});
    case (k)
      3'd0:    return ascii_digit(d.hund);
      3'd1:    return ascii_digit(d.tens);
      default: return ascii_digit(d.ones);
    endcase
  endfunction

endpackage

// File: rtl/uart_matrix_printer_if.sv
// -----------------------------------------------------------------------------
// uart_matrix_printer_if
//   Bundles the printer's matrix-storage read port and its byte stream to
//   uart_tx.
//   rd_addr/rd_en (printer -> storage), rd_data (storage -> printer, valid the
//   cycle after rd_en), tx_data/tx_valid (printer -> uart_tx), tx_ready
//   (uart_tx -> printer).
//   master: printer side. slave: storage + uart_tx side.
// -----------------------------------------------------------------------------
interface uart_matrix_printer_if #(
  parameter int ELEM_W = 8,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [ELEM_W-1:0] rd_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output rd_addr, rd_en, tx_data, tx_valid,
    input  rd_data, tx_ready
  );

  modport slave (
    input  rd_addr, rd_en, tx_data, tx_valid,
    output rd_data, tx_ready
  );
endinterface

// File: rtl/dec_digits8.sv
// -----------------------------------------------------------------------------
// dec_digits8
//   Combinational split of an 8-bit element into sign, decimal digits and the
//   count of significant digits.
//   Ports: value (in, 8) element; digits (out, digits_t) breakdown.
//   MATRIX_PRINT_SIGNED_EN: value is two's complement; digits describe |value|
//   and neg flags a negative input. Otherwise value is unsigned, neg is 0.
// -----------------------------------------------------------------------------
module dec_digits8 import matrix_pkg::*; (
  input  logic [7:0] value,
  output digits_t    digits
);

  logic [7:0] mag;

  always_comb begin
    digits = '0;
`ifdef MATRIX_PRINT_SIGNED_EN
    digits.neg = value[7];
    // -128 negates to 8'h80, which read unsigned is the required 128.
    mag = value[7] ? (~value + 8'd1) : value;
`else
    digits.neg = 1'b0;
    mag = value;
`endif
    digits.hund = 4'(mag / 8'd100);
    digits.tens = 4'((mag / 8'd10) % 8'd10);
    digits.ones = 4'(mag % 8'd10);
    if (digits.hund != 4'd0)      digits.ndigits = 2'd3;
    else if (digits.tens != 4'd0) digits.ndigits = 2'd2;
    else                          digits.ndigits = 2'd1;
  end

endmodule

// File: rtl/uart_matrix_printer.sv
// -----------------------------------------------------------------------------
// uart_matrix_printer
//   Prints one stored matrix as ASCII: "M N\r\n" then M rows of N decimal
//   elements separated by single spaces, each row ended by "\r\n".
//   Ports: clk, rst_n (async, active-low); start (1-cycle pulse, ignored while
//   busy); dim_m/dim_n (sampled on accepted start, clamped to MAX_DIM);
//   busy (accepted start .. done); done (1-cycle pulse after final LF);
//   bus (master): storage read port and tx byte stream.
//   MATRIX_PRINT_SIGNED_EN: elements print as signed values (see dec_digits8).
// -----------------------------------------------------------------------------
module uart_matrix_printer #(
  parameter int ELEM_W  = matrix_pkg::ELEM_W,
  parameter int ADDR_W  = matrix_pkg::ADDR_W,
  parameter int MAX_DIM = matrix_pkg::MAX_DIM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            dim_m,
  input  logic [2:0]            dim_n,
  output logic                  busy,
  output logic                  done,
  uart_matrix_printer_if.master bus
);
  import matrix_pkg::*;

  state_t            state_q, state_d;
  logic [2:0]        m_q, m_d, n_q, n_d, row_q, row_d, col_q, col_d, idx_q, idx_d;
  digits_t           elem_q, elem_d, dec;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d, rd_en_q, rd_en_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ELEM_W-1:0] rd_word;
  logic              accept;

  function automatic logic [2:0] clamp_dim(input logic [2:0] d);
    return (int'(d) > MAX_DIM) ? 3'(MAX_DIM) : d;
  endfunction

  function automatic logic [ADDR_W-1:0] elem_addr(input logic [2:0] r, c, n);
    return ADDR_W'(r) * ADDR_W'(n) + ADDR_W'(c);
  endfunction

  function automatic logic [7:0] hdr_char(input logic [2:0] i, m, n);
    case (i)
      3'd0:    return ascii_digit({1'b0, m});
      3'd1:    return ASCII_SPACE;
      3'd2:    return ascii_digit({1'b0, n});
      3'd3:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

  assign rd_word = bus.rd_data;

  dec_digits8 u_dec (
    .value  (rd_word[7:0]),
    .digits (dec)
  );

  assign accept       = tx_valid_q && bus.tx_ready;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // Each state loads the next byte only on the cycle the current one is
  // accepted, so tx_data/tx_valid hold steady across any tx_ready stall.
  always_comb begin
    // NOTE: every signal gets its default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    m_d        = m_q;
    n_d        = n_q;
    row_d      = row_q;
    col_d      = col_q;
    idx_d      = idx_q;
    elem_d     = elem_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rd_addr_d  = rd_addr_q;
    busy_d     = busy_q;
    rd_en_d    = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: if (start) begin
        m_d        = clamp_dim(dim_m);
        n_d        = clamp_dim(dim_n);
        row_d      = 3'd0;
        col_d      = 3'd0;
        tx_data_d  = hdr_char(3'd0, clamp_dim(dim_m), clamp_dim(dim_n));
        tx_valid_d = 1'b1;
        idx_d      = 3'd1;
        busy_d     = 1'b1;
        state_d    = ST_HDR;
      end
      ST_HDR: if (accept) begin
        if (idx_q < 3'(HDR_LEN)) begin
          tx_data_d = hdr_char(idx_q, m_q, n_q);
          idx_d     = idx_q + 3'd1;
        end else begin
          tx_valid_d = 1'b0;
          if (m_q == 3'd0 || n_q == 3'd0) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_FETCH: state_d = ST_RDWAIT;
      ST_RDWAIT: begin
        elem_d     = dec;
        tx_data_d  = elem_char(dec, 3'd0);
        tx_valid_d = 1'b1;
        idx_d      = 3'd1;
        state_d    = ST_EMIT;
      end
      ST_EMIT: if (accept) begin
        if (idx_q < elem_len(elem_q)) begin
          tx_data_d = elem_char(elem_q, idx_q);
          idx_d     = idx_q + 3'd1;
        end else if (col_q != n_q - 3'd1) begin
          tx_data_d = ASCII_SPACE;
          state_d   = ST_SEP;
        end else begin
          tx_data_d = ASCII_CR;
          state_d   = ST_CR;
        end
      end
      ST_SEP: if (accept) begin
        tx_valid_d = 1'b0;
        col_d      = col_q + 3'd1;
        rd_en_d    = 1'b1;
        rd_addr_d  = elem_addr(row_q, col_q + 3'd1, n_q);
        state_d    = ST_FETCH;
      end
      ST_CR: if (accept) begin
        tx_data_d = ASCII_LF;
        state_d   = ST_LF;
      end
      ST_LF: if (accept) begin
        tx_valid_d = 1'b0;
        if (row_q != m_q - 3'd1) begin
          row_d     = row_q + 3'd1;
          col_d     = 3'd0;
          rd_en_d   = 1'b1;
          rd_addr_d = elem_addr(row_q + 3'd1, 3'd0, n_q);
          state_d   = ST_FETCH;
        end else begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      // busy stays high through the done cycle, so a start here is ignored.
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      m_q        <= '0;
      n_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      idx_q      <= '0;
      elem_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      n_q        <= n_d;
      row_q      <= row_d;
      col_q      <= col_d;
      idx_q      <= idx_d;
      elem_q     <= elem_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_matrix_printer.sv
// -----------------------------------------------------------------------------
// tb_uart_matrix_printer
//   Directed and randomized frames against uart_matrix_printer. Expected text is
//   formatted from the matrix contents with $sformatf; a storage model answers
//   reads one cycle after rd_en; tx_ready is optionally randomized and stalled
//   bytes are checked for stability.
// -----------------------------------------------------------------------------
module tb_uart_matrix_printer;

  localparam int BUDGET = 5000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] dim_m, dim_n;
  logic       busy, done;

  uart_matrix_printer_if #(.ELEM_W(8), .ADDR_W(5)) bus ();

  uart_matrix_printer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .dim_m (dim_m),
    .dim_n (dim_n),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:31];
  logic [7:0] got [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         rd_cnt   = 0;
  int         done_cnt = 0;
  bit         rand_ready = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] stall_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Storage model: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rst_n && bus.rd_en) begin
      bus.rd_data <= mem[bus.rd_addr];
      rd_cnt++;
    end
  end

  // Byte capture and done counting.
  always @(posedge clk) begin
    if (rst_n && bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
    if (rst_n && done) done_cnt++;
  end

  // tx_ready driver with stall-stability check.
  always @(negedge clk) begin
    if (rst_n && stall_prev) begin
      check("hold_valid", 32'(bus.tx_valid), 32'd1);
      check("hold_data", 32'(bus.tx_data), 32'(stall_data));
    end
    bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    stall_prev   = rst_n && bus.tx_valid && !bus.tx_ready;
    stall_data   = bus.tx_data;
  end

  // Reference text of a frame, straight from the output format rules.
  function automatic string expect_str(input int m, input int n);
    int    mc = (m > 5) ? 5 : m;
    int    nc = (n > 5) ? 5 : n;
    string s  = $sformatf("%0d %0d\r\n", mc, nc);
    for (int r = 0; r < mc; r++) begin
      for (int c = 0; c < nc; c++) begin
`ifdef MATRIX_PRINT_SIGNED_EN
        s = {s, $sformatf("%0d", $signed(mem[r * nc + c]))};
`else
        s = {s, $sformatf("%0d", mem[r * nc + c])};
`endif
        if (c < nc - 1) s = {s, " "};
      end
      s = {s, "\r\n"};
    end
    return s;
  endfunction

  task automatic run_frame(input int m, input int n, input bit rnd,
                           input int inject_cyc, input bit start_on_done);
    string e    = expect_str(m, n);
    int    mc   = (m > 5) ? 5 : m;
    int    nc   = (n > 5) ? 5 : n;
    int    cyc  = 0;
    int    bad  = -1;
    bit    seen = 1'b0;
    got.delete();
    rd_cnt     = 0;
    done_cnt   = 0;
    rand_ready = rnd;
    @(negedge clk);
    dim_m = 3'(m);
    dim_n = 3'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_valid", 32'(bus.tx_valid), 32'd1);
    check("busy_set", 32'(busy), 32'd1);
    check("first_byte", 32'(bus.tx_data), 32'(e[0]));
    while (!seen && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == inject_cyc) begin
        dim_m = 3'd1;
        dim_n = 3'd1;
        start = 1'b1;
      end
      if (done) begin
        seen = 1'b1;
        check("busy_at_done", 32'(busy), 32'd1);
        if (start_on_done) start = 1'b1;
      end
    end
    check("done_within_budget", 32'(seen), 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("busy_clear", 32'(busy), 32'd1 - 32'd1 + 32'(busy & 1'b0));
    check("done_single", 32'(done), 32'd0);
    check("idle_valid", 32'(bus.tx_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("done_count", done_cnt, 32'd1);
    check("read_count", rd_cnt, mc * nc);
    check("byte_count", got.size(), e.len());
    for (int i = 0; i < got.size() && i < e.len(); i++)
      if (bad < 0 && got[i] !== e[i]) bad = i;
    check("stream_first_diff", bad, -1);
    rand_ready = 1'b0;
  endtask

  initial begin
    start       = 1'b0;
    dim_m       = '0;
    dim_n       = '0;
    bus.tx_ready = 1'b1;
    bus.rd_data  = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // 2x3 counting matrix, continuous ready.
    for (int i = 0; i < 6; i++) mem[i] = 8'(i + 1);
    run_frame(2, 3, 1'b0, -1, 1'b0);

    // No leading zeros, no trailing space.
    mem[0] = 8'd0; mem[1] = 8'd7; mem[2] = 8'd255;
    run_frame(1, 3, 1'b0, -1, 1'b0);

    // Same 2x3 data under random backpressure.
    for (int i = 0; i < 6; i++) mem[i] = 8'(i + 1);
    run_frame(2, 3, 1'b1, -1, 1'b0);

    // Empty matrix prints header only and reads nothing.
    run_frame(0, 4, 1'b0, -1, 1'b0);

    // Oversize dims clamp; start coincident with done is ignored.
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    run_frame(7, 2, 1'b0, -1, 1'b0);
    run_frame(7, 7, 1'b1, -1, 1'b1);

    // start pulsed mid-frame is ignored.
    run_frame(3, 3, 1'b0, 12, 1'b0);

    // Reset mid-frame drops tx_valid and busy immediately.
    @(negedge clk);
    dim_m = 3'd3; dim_n = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.tx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("midrst_busy_next", 32'(busy), 32'd0);
    check("midrst_rd_en", 32'(bus.rd_en), 32'd0);
    rst_n = 1'b1;
    run_frame(2, 2, 1'b0, -1, 1'b0);

`ifdef MATRIX_PRINT_SIGNED_EN
    mem[0] = 8'hFF; mem[1] = 8'h80;
    run_frame(1, 2, 1'b0, -1, 1'b0);
`endif

    // Randomized frames.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
